// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: run controller for the special-sequence counter.
// Accepts a run request and optionally clears the counter for one cycle.
// It then issues Steps enable pulses, one every STEP_DIV cycles, and
// signals completion with a one-cycle Done pulse. Abort and Reset end a
// run early without Done.
// Optional build macro SEQ_CHECK_EN adds a sequence checker. The checker
// compares the counter's Q against the legal order
// 000->001->011->101->111->010->000 and sets a sticky Error on any
// violation. Without the macro, Error is tied low.
module seq_run_ctrl #(
    parameter int STEP_DIV = 1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic [7:0] Steps,
    input  logic       Clear_First,
    input  logic [2:0] Q,
    output logic       Ctr_Reset,
    output logic       Ctr_Enable,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Remaining,
    output logic       Error
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam logic [3:0] PACE_RELOAD = 4'(STEP_DIV - 1);

    state_t     state, state_nxt;
    logic [3:0] pace, pace_nxt;
    logic [7:0] rem_nxt;
    logic       accept;

    // State, pace counter and remaining-advance count registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            pace      <= 4'd0;
            Remaining <= 8'd0;
        end else begin
            state     <= state_nxt;
            pace      <= pace_nxt;
            Remaining <= rem_nxt;
        end
    end

    // Next-state and output decode; Abort suppresses counter strobes in the same cycle
    always_comb begin
        state_nxt  = state;
        pace_nxt   = pace;
        rem_nxt    = Remaining;
        Ctr_Reset  = 1'b0;
        Ctr_Enable = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept   = 1'b1;
                    rem_nxt  = Steps;
                    pace_nxt = PACE_RELOAD;
                    if (Steps == 8'd0)
                        state_nxt = DONE;
                    else if (Clear_First)
                        state_nxt = CLEAR;
                    else
                        state_nxt = RUN;
                end
            end
            CLEAR: begin
                Busy = 1'b1;
                if (Abort) begin
                    state_nxt = IDLE;
                    rem_nxt   = 8'd0;
                end else begin
                    Ctr_Reset = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (Abort) begin
                    state_nxt = IDLE;
                    rem_nxt   = 8'd0;
                end else if (pace == 4'd0) begin
                    Ctr_Enable = 1'b1;
                    pace_nxt   = PACE_RELOAD;
                    rem_nxt    = Remaining - 8'd1;
                    if (Remaining == 8'd1)
                        state_nxt = DONE;
                end else begin
                    pace_nxt = pace - 4'd1;
                end
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SEQ_CHECK_EN
    logic       chk_vld;
    logic [2:0] chk_q;
    logic       seq_bad;

    function automatic logic [2:0] seq_succ(input logic [2:0] cur);
        case (cur)
            3'b000:  seq_succ = 3'b001;
            3'b001:  seq_succ = 3'b011;
            3'b011:  seq_succ = 3'b101;
            3'b101:  seq_succ = 3'b111;
            3'b111:  seq_succ = 3'b010;
            default: seq_succ = 3'b000;
        endcase
    endfunction

    // Violation: wrong value after a strobe, or an unused code while busy
    always_comb begin
        seq_bad = 1'b0;
        if (chk_vld && (Q != chk_q))
            seq_bad = 1'b1;
        if (Busy && ((Q == 3'b100) || (Q == 3'b110)))
            seq_bad = 1'b1;
    end

    // Capture the value expected after each strobe; keep Error sticky until a new run
    always_ff @(posedge CLK) begin
        if (Reset) begin
            chk_vld <= 1'b0;
            chk_q   <= 3'b000;
            Error   <= 1'b0;
        end else begin
            chk_vld <= Ctr_Enable | Ctr_Reset;
            chk_q   <= Ctr_Enable ? seq_succ(Q) : 3'b000;
            if (accept)
                Error <= 1'b0;
            else if (seq_bad)
                Error <= 1'b1;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{Q, accept};
    assign Error      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_run_ctrl.sv
// tb_seq_run_ctrl: directed and randomized runs on two instances, with
// STEP_DIV=1 and STEP_DIV=3. Expected outputs are computed per cycle from
// the run timeline: the clear cycle, enables every D cycles, the done
// cycle, and the abort point. Each instance drives a behavioural counter
// that advances through the legal sequence.
module tb_seq_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       abort [2];
    logic       cf    [2];
    logic [7:0] steps [2];
    logic [2:0] qm    [2];
    logic       ctr_rst [2];
    logic       ctr_en  [2];
    logic       busy    [2];
    logic       done    [2];
    logic       err     [2];
    logic [7:0] rem     [2];
    bit         corrupt [2];
    bit         qzap    [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_run_ctrl #(.STEP_DIV(1)) u_d1 (
        .CLK(clk), .Reset(rst), .Start(start[0]), .Abort(abort[0]),
        .Steps(steps[0]), .Clear_First(cf[0]), .Q(qm[0]),
        .Ctr_Reset(ctr_rst[0]), .Ctr_Enable(ctr_en[0]), .Busy(busy[0]),
        .Done(done[0]), .Remaining(rem[0]), .Error(err[0])
    );

    seq_run_ctrl #(.STEP_DIV(3)) u_d3 (
        .CLK(clk), .Reset(rst), .Start(start[1]), .Abort(abort[1]),
        .Steps(steps[1]), .Clear_First(cf[1]), .Q(qm[1]),
        .Ctr_Reset(ctr_rst[1]), .Ctr_Enable(ctr_en[1]), .Busy(busy[1]),
        .Done(done[1]), .Remaining(rem[1]), .Error(err[1])
    );

    function automatic logic [2:0] seq_next(input logic [2:0] cur);
        logic [2:0] ord [6];
        ord = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b010};
        seq_next = 3'b000;
        for (int i = 0; i < 6; i++)
            if (ord[i] == cur) seq_next = ord[(i + 1) % 6];
    endfunction

    // Behavioural counters driven by each instance's strobes
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (qzap[u] || ctr_rst[u])
                qm[u] <= 3'b000;
            else if (ctr_en[u])
                qm[u] <= (corrupt[u] && qm[u] == 3'b011) ? 3'b100 : seq_next(qm[u]);
        end
    end

    task automatic chk(input string tag, input int u, input int t,
                       input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s u=%0d t=%0d observed=%0d expected=%0d", tag, u, t, obs, exp_v);
        end
    endtask

    // One run from an idle instance: Start at t=0, optional Abort at ta,
    // optional ignored Start at ts. err_from is the first cycle Error is high.
    task automatic run_check(input int u, input int d, input int s, input bit c,
                             input bit a0, input int ta, input int ts,
                             input int err_from, input bit prev_err);
        int off, be, tend, k, er;
        bit ab, live;
        logic e_busy, e_clr, e_en, e_done, e_err;
        off  = (c && s != 0) ? 1 : 0;
        be   = (s == 0) ? 0 : off + s * d;
        ab   = (ta >= 1 && ta <= be);
        tend = be + 3;
        if (ta + 2 > tend) tend = ta + 2;
        for (int t = 0; t <= tend; t++) begin
            @(negedge clk);
            start[u] = (t == 0) || (ts > 0 && t == ts);
            steps[u] = (t == 0) ? 8'(s) : 8'($urandom);
            cf[u]    = (t == 0) ? c : 1'($urandom);
            abort[u] = (t == 0) ? a0 : (t == ta);
            #1;
            if (t == 0) begin
                e_busy = 0; e_clr = 0; e_en = 0; e_done = 0; er = 0;
                e_err = prev_err;
            end else begin
                live   = !(ab && t >= ta);
                e_busy = (s != 0) && t <= be && !(ab && t > ta);
                e_clr  = c && (s != 0) && t == 1 && live;
                e_en   = (s != 0) && t > off && t <= be && ((t - off) % d == 0) && live;
                e_done = !ab && t == be + 1;
                if ((ab && t > ta) || t > be) er = 0;
                else begin
                    k  = (t - 1 >= off) ? (t - 1 - off) / d : 0;
                    if (k > s) k = s;
                    er = s - k;
                end
                e_err = (err_from != 0) && t >= err_from;
            end
            chk("busy", u, t, 8'(busy[u]), 8'(e_busy));
            chk("ctr_reset", u, t, 8'(ctr_rst[u]), 8'(e_clr));
            chk("ctr_enable", u, t, 8'(ctr_en[u]), 8'(e_en));
            chk("done", u, t, 8'(done[u]), 8'(e_done));
            chk("remaining", u, t, rem[u], 8'(er));
            chk("error", u, t, 8'(err[u]), 8'(e_err));
        end
        start[u] = 0; abort[u] = 0;
    endtask

    task automatic zap_counter(input int u);
        @(negedge clk); qzap[u] = 1;
        @(negedge clk); qzap[u] = 0;
    endtask

    initial begin
        int s, d, ta, ts, be, mx, ef;
        bit c;
        rst = 1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 0; abort[u] = 0; cf[u] = 0; steps[u] = 8'd0;
            corrupt[u] = 0; qzap[u] = 1;
        end
        start[0] = 1; abort[1] = 1;
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", u, 0, 8'(busy[u]), 8'd0);
            chk("rst_done", u, 0, 8'(done[u]), 8'd0);
            chk("rst_enable", u, 0, 8'(ctr_en[u]), 8'd0);
            chk("rst_ctr_reset", u, 0, 8'(ctr_rst[u]), 8'd0);
            chk("rst_remaining", u, 0, rem[u], 8'd0);
            chk("rst_error", u, 0, 8'(err[u]), 8'd0);
        end
        @(negedge clk);
        rst = 0; start[0] = 0; abort[1] = 0; qzap[0] = 0; qzap[1] = 0;

        // D=1, 6 steps with clear, Abort held during idle Start cycle
        run_check(0, 1, 6, 1, 1, 0, 0, 0, 0);
        // D=3, 2 steps, no clear
        run_check(1, 3, 2, 0, 0, 0, 0, 0, 0);
        // zero steps on both instances
        run_check(0, 1, 0, 1, 0, 0, 1, 0, 0);
        run_check(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // 10 steps, Abort right after the 4th enable, Start ignored mid-run
        run_check(0, 1, 10, 0, 0, 5, 3, 0, 0);
        // Abort during the clear cycle
        run_check(1, 3, 4, 1, 0, 1, 0, 0, 0);
        // Abort landing on the Done cycle has no effect
        run_check(1, 3, 2, 0, 0, 7, 0, 0, 0);

        // counter jumps 011 -> 100: Error from t=6 when the checker is built
        zap_counter(0);
        corrupt[0] = 1;
`ifdef SEQ_CHECK_EN
        ef = 6;
`else
        ef = 0;
`endif
        run_check(0, 1, 4, 1, 0, 0, 0, ef, 0);
        corrupt[0] = 0;
        zap_counter(0);
        run_check(0, 1, 3, 1, 0, 0, 0, 0, ef != 0);

        // Reset mid-run with Start high abandons the run
        @(negedge clk);
        start[1] = 1; steps[1] = 8'd5; cf[1] = 0;
        @(negedge clk);
        start[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1; start[1] = 1; steps[1] = 8'd9;
        @(negedge clk);
        rst = 0; start[1] = 0;
        #1;
        chk("rst_mid_busy", 1, 0, 8'(busy[1]), 8'd0);
        chk("rst_mid_enable", 1, 0, 8'(ctr_en[1]), 8'd0);
        chk("rst_mid_ctr_reset", 1, 0, 8'(ctr_rst[1]), 8'd0);
        chk("rst_mid_done", 1, 0, 8'(done[1]), 8'd0);
        chk("rst_mid_remaining", 1, 0, rem[1], 8'd0);
        chk("rst_mid_error", 1, 0, 8'(err[1]), 8'd0);
        run_check(1, 3, 3, 0, 0, 0, 0, 0, 0);

        // randomized runs
        for (int i = 0; i < 14; i++) begin
            d  = (i % 2 == 1) ? 3 : 1;
            s  = (i == 5) ? 255 : int'($urandom_range(0, 20));
            c  = 1'($urandom);
            be = (s == 0) ? 0 : (c ? 1 : 0) + s * d;
            ta = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, be + 2)) : 0;
            mx = (ta >= 1 && ta <= be) ? ta : be + 1;
            ts = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, mx)) : 0;
            run_check(i % 2, d, s, c, 1'($urandom), ta, ts, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
